// File: rtl/ticket_printer_arbiter_if.sv
// Kiosk and printer handshake bundle for the ticket printer arbiter.
// master = arbiter side, slave = kiosks plus printer driver side.
interface ticket_printer_arbiter_if #(
  parameter int N_KIOSK = 4
);
  logic [N_KIOSK-1:0]   req;
  logic [4*N_KIOSK-1:0] job_start;
  logic [4*N_KIOSK-1:0] job_dest;
  logic [7*N_KIOSK-1:0] job_fare;
  logic [N_KIOSK-1:0]   ack;
  logic [N_KIOSK-1:0]   done;
  logic [N_KIOSK-1:0]   fail;
  logic                 prn_valid;
  logic                 prn_ready;
  logic [3:0]           prn_start;
  logic [3:0]           prn_dest;
  logic [6:0]           prn_fare;
  logic                 prn_done;

  modport master (
    input  req, job_start, job_dest, job_fare,
    input  prn_ready, prn_done,
    output ack, done, fail,
    output prn_valid, prn_start, prn_dest, prn_fare
  );

  modport slave (
    output req, job_start, job_dest, job_fare,
    output prn_ready, prn_done,
    input  ack, done, fail,
    input  prn_valid, prn_start, prn_dest, prn_fare
  );
endinterface

// File: rtl/ticket_printer_arbiter.sv
// Round-robin arbiter sharing one ticket printer between kiosks.
// Validates each job at grant and guards the printer with a watchdog.
module ticket_printer_arbiter #(
  parameter int N_KIOSK = 4,
  parameter int TIMEOUT = 200
) (
  input  logic                       clk,
  input  logic                       reset,
  ticket_printer_arbiter_if.master   bus,
  output logic                       busy,
  output logic [$clog2(N_KIOSK)-1:0] owner,
  output logic [7:0]                 jobs_printed
);
  localparam int W  = $clog2(N_KIOSK);
  localparam int IW = W + 1;
  localparam logic [IW-1:0] NK = IW'(N_KIOSK);
  localparam logic [N_KIOSK-1:0] ONE = N_KIOSK'(1);
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    PRINT = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [W-1:0] rr_ptr;
  logic [7:0]   wd;

  logic         found;
  logic [W-1:0] sel;
  logic [IW-1:0] idx;
  logic [IW-1:0] rr_inc;
  logic [3:0]   sel_start;
  logic [3:0]   sel_dest;
  logic [6:0]   sel_fare;
  logic         job_ok;
  logic         wd_hit;

  logic [N_KIOSK-1:0] ack_nx;
  logic [N_KIOSK-1:0] done_nx;
  logic [N_KIOSK-1:0] fail_nx;
  logic               valid_nx;
  logic               busy_nx;
  logic [W-1:0]       owner_nx;
  logic [3:0]         start_nx;
  logic [3:0]         dest_nx;
  logic [6:0]         fare_nx;
  logic [7:0]         wd_nx;
  logic [W-1:0]       rr_nx;
  logic [7:0]         cnt_nx;

  // Rotating-priority pick: first request at or above rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < N_KIOSK; i++) begin
      idx = {1'b0, rr_ptr} + IW'(i);
      if (idx >= NK) idx = idx - NK;
      if (!found && bus.req[idx[W-1:0]]) begin
        found = 1'b1;
        sel   = idx[W-1:0];
      end
    end
    rr_inc = {1'b0, sel} + IW'(1);
    if (rr_inc == NK) rr_inc = '0;
    sel_start = bus.job_start[int'(sel)*4 +: 4];
    sel_dest  = bus.job_dest[int'(sel)*4 +: 4];
    sel_fare  = bus.job_fare[int'(sel)*7 +: 7];
    job_ok = (sel_start >= 4'd1) && (sel_start <= 4'd10)
          && (sel_dest >= 4'd1) && (sel_dest <= 4'd10)
          && (sel_start != sel_dest)
          && (sel_fare != 7'd0);
    wd_hit = (wd == WD_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: completion beats watchdog expiry in PRINT.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (found && job_ok) state_nx = SEND;
      end
      SEND: begin
        if (wd_hit)             state_nx = IDLE;
        else if (bus.prn_ready) state_nx = PRINT;
      end
      PRINT: begin
        if (bus.prn_done || wd_hit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output next values; everything visible is registered below.
  always_comb begin
    ack_nx   = '0;
    done_nx  = '0;
    fail_nx  = '0;
    valid_nx = (state_nx == SEND);
    busy_nx  = (state_nx != IDLE);
    owner_nx = owner;
    start_nx = bus.prn_start;
    dest_nx  = bus.prn_dest;
    fare_nx  = bus.prn_fare;
    wd_nx    = wd;
    rr_nx    = rr_ptr;
    cnt_nx   = jobs_printed;
    unique case (state)
      IDLE: begin
        if (found) begin
          ack_nx   = ONE << sel;
          owner_nx = sel;
          start_nx = sel_start;
          dest_nx  = sel_dest;
          fare_nx  = sel_fare;
          rr_nx    = rr_inc[W-1:0];
          wd_nx    = '0;
          if (!job_ok) fail_nx = ONE << sel;
        end
      end
      SEND, PRINT: begin
        wd_nx = wd + 8'd1;
        if (state == PRINT && bus.prn_done) begin
          done_nx = ONE << owner;
          cnt_nx  = jobs_printed + 8'd1;
        end else if (wd_hit) begin
          fail_nx = ONE << owner;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers; reset abandons any job silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.ack       <= '0;
      bus.done      <= '0;
      bus.fail      <= '0;
      bus.prn_valid <= 1'b0;
      bus.prn_start <= '0;
      bus.prn_dest  <= '0;
      bus.prn_fare  <= '0;
      busy          <= 1'b0;
      owner         <= '0;
      wd            <= '0;
      rr_ptr        <= '0;
      jobs_printed  <= '0;
    end else begin
      bus.ack       <= ack_nx;
      bus.done      <= done_nx;
      bus.fail      <= fail_nx;
      bus.prn_valid <= valid_nx;
      bus.prn_start <= start_nx;
      bus.prn_dest  <= dest_nx;
      bus.prn_fare  <= fare_nx;
      busy          <= busy_nx;
      owner         <= owner_nx;
      wd            <= wd_nx;
      rr_ptr        <= rr_nx;
      jobs_printed  <= cnt_nx;
    end
  end
endmodule

// File: tb/tb_ticket_printer_arbiter.sv
// Directed bench for ticket_printer_arbiter, four kiosks.
// Watchdog limit shortened to 16 cycles.
module tb_ticket_printer_arbiter;
  localparam int NK = 4;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [1:0] owner;
  logic [7:0] jobs_printed;

  int checks = 0;
  int failures = 0;

  ticket_printer_arbiter_if #(.N_KIOSK(NK)) bus ();

  ticket_printer_arbiter #(
    .N_KIOSK(NK),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .owner(owner),
    .jobs_printed(jobs_printed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int k, input logic [3:0] s,
                         input logic [3:0] d, input logic [6:0] f);
    bus.job_start[4*k +: 4] = s;
    bus.job_dest[4*k +: 4]  = d;
    bus.job_fare[7*k +: 7]  = f;
  endtask

  task automatic wait_ack(output logic [3:0] a);
    a = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.ack != 4'b0) begin
        a = bus.ack;
        break;
      end
    end
  endtask

  task automatic complete(output logic [3:0] d);
    tick();
    bus.prn_done = 1'b1;
    tick();
    d = bus.done;
    bus.prn_done = 1'b0;
  endtask

  logic [3:0] a;
  logic [3:0] d;
  logic [3:0] acc;
  int exp_k;

  initial begin
    reset         = 1'b0;
    bus.req       = '0;
    bus.job_start = '0;
    bus.job_dest  = '0;
    bus.job_fare  = '0;
    bus.prn_ready = 1'b1;
    bus.prn_done  = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    check("rst_ack", bus.ack, 0);
    check("rst_done", bus.done, 0);
    check("rst_fail", bus.fail, 0);
    check("rst_valid", bus.prn_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_jobs", jobs_printed, 0);
    check("rst_start", bus.prn_start, 0);

    // single job on kiosk 1
    set_job(1, 4'd2, 4'd7, 7'd50);
    bus.req = 4'b0010;
    wait_ack(a);
    bus.req = '0;
    check("s_ack", a, 4'b0010);
    check("s_valid", bus.prn_valid, 1);
    check("s_busy", busy, 1);
    check("s_owner", owner, 1);
    check("s_start", bus.prn_start, 2);
    check("s_dest", bus.prn_dest, 7);
    check("s_fare", bus.prn_fare, 50);
    tick();
    check("s_ack_1w", bus.ack, 0);
    check("s_valid_drop", bus.prn_valid, 0);
    check("s_busy_print", busy, 1);
    tick();
    bus.prn_done = 1'b1;
    tick();
    bus.prn_done = 1'b0;
    check("s_done", bus.done, 4'b0010);
    check("s_jobs", jobs_printed, 1);
    check("s_busy_low", busy, 0);
    tick();
    check("s_done_1w", bus.done, 0);

    // round robin from a fresh pointer
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < NK; k++)
      set_job(k, 4'(k + 1), 4'(k + 5), 7'(k + 10));
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_k = n % NK;
      wait_ack(a);
      if (n == 4) bus.req = '0;
      check($sformatf("rr_ack%0d", n), a, 4'b1 << exp_k);
      check($sformatf("rr_start%0d", n),
            bus.prn_start, exp_k + 1);
      complete(d);
      check($sformatf("rr_done%0d", n), d, 4'b1 << exp_k);
    end
    // move pointer to 2, then 0 must beat 1
    bus.req = 4'b0010;
    wait_ack(a);
    bus.req = '0;
    check("rr_k1", a, 4'b0010);
    complete(d);
    bus.req = 4'b0011;
    wait_ack(a);
    bus.req = 4'b0010;
    check("rr_first0", a, 4'b0001);
    complete(d);
    wait_ack(a);
    bus.req = '0;
    check("rr_then1", a, 4'b0010);
    complete(d);
    check("rr_jobs", jobs_printed, 8);

    // invalid jobs on kiosk 3
    for (int v = 0; v < 3; v++) begin
      case (v)
        0: set_job(3, 4'd4, 4'd4, 7'd20);
        1: set_job(3, 4'd4, 4'd11, 7'd20);
        default: set_job(3, 4'd2, 4'd3, 7'd0);
      endcase
      bus.req = 4'b1000;
      wait_ack(a);
      bus.req = '0;
      check($sformatf("inv_ack%0d", v), a, 4'b1000);
      check($sformatf("inv_fail%0d", v), bus.fail, 4'b1000);
      check($sformatf("inv_valid%0d", v), bus.prn_valid, 0);
      check($sformatf("inv_busy%0d", v), busy, 0);
      tick();
      check($sformatf("inv_valid_n%0d", v), bus.prn_valid, 0);
      check($sformatf("inv_fail_1w%0d", v), bus.fail, 0);
    end
    check("inv_jobs", jobs_printed, 8);

    // watchdog timeout with printer never ready
    bus.prn_ready = 1'b0;
    set_job(0, 4'd3, 4'd9, 7'd40);
    bus.req = 4'b0001;
    wait_ack(a);
    bus.req = '0;
    check("to_ack", a, 4'b0001);
    acc = '0;
    for (int i = 1; i < TO; i++) begin
      tick();
      acc |= bus.fail;
    end
    check("to_nofail_early", acc, 0);
    check("to_valid_held", bus.prn_valid, 1);
    tick();
    check("to_fail", bus.fail, 4'b0001);
    check("to_valid_low", bus.prn_valid, 0);
    check("to_busy_low", busy, 0);
    tick();
    check("to_fail_1w", bus.fail, 0);
    bus.prn_done = 1'b1;
    tick();
    bus.prn_done = 1'b0;
    check("idle_done_ign", bus.done, 0);
    check("to_jobs", jobs_printed, 8);

    // done and timeout on the same edge
    bus.prn_ready = 1'b1;
    set_job(2, 4'd5, 4'd1, 7'd33);
    bus.req = 4'b0100;
    wait_ack(a);
    bus.req = '0;
    check("race_ack", a, 4'b0100);
    tick();
    acc = '0;
    for (int i = 2; i < TO; i++) begin
      tick();
      acc |= bus.done | bus.fail;
    end
    check("race_quiet", acc, 0);
    bus.prn_done = 1'b1;
    tick();
    bus.prn_done = 1'b0;
    check("race_done", bus.done, 4'b0100);
    check("race_nofail", bus.fail, 0);
    check("race_jobs", jobs_printed, 9);

    // reset while printing
    set_job(1, 4'd6, 4'd8, 7'd12);
    bus.req = 4'b0010;
    wait_ack(a);
    bus.req = '0;
    check("mr_ack", a, 4'b0010);
    tick();
    tick();
    check("mr_busy_pre", busy, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mr_done", bus.done, 0);
    check("mr_fail", bus.fail, 0);
    check("mr_valid", bus.prn_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_owner", owner, 0);
    check("mr_jobs", jobs_printed, 0);
    check("mr_start", bus.prn_start, 0);
    bus.prn_done = 1'b1;
    tick();
    bus.prn_done = 1'b0;
    check("mr_done_ign", bus.done | bus.fail, 0);
    set_job(2, 4'd10, 4'd1, 7'd99);
    bus.req = 4'b0100;
    wait_ack(a);
    bus.req = '0;
    check("mr_new_ack", a, 4'b0100);
    check("mr_new_owner", owner, 2);
    check("mr_new_fare", bus.prn_fare, 99);
    complete(d);
    check("mr_new_done", d, 4'b0100);
    check("mr_new_jobs", jobs_printed, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ticket_printer_arbiter.md
# ticket_printer_arbiter

Shares one ticket printer between N_KIOSK ticket-machine kiosks. Each kiosk's fare FSM raises a print request carrying start station, destination station and fare. The arbiter grants kiosks in round-robin order, forwards the job over a valid/ready interface, and waits for the printer's completion strobe. It then reports success or timeout back to the owning kiosk. It sits between the kiosk fare controllers and the single printer driver.

## Interface
Parameters:
- N_KIOSK, 4: number of requesting kiosks, 2..8.
- TIMEOUT, 200: watchdog limit in cycles, 2..255.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
- req  in  N_KIOSK  per-kiosk print request; held high with job fields stable until ack.
- job_start  in  4*N_KIOSK  start station per kiosk; kiosk i uses bits [4i+3:4i].
- job_dest  in  4*N_KIOSK  destination station per kiosk, same packing.
- job_fare  in  7*N_KIOSK  fare per kiosk; kiosk i uses bits [7i+6:7i].
- ack  out  N_KIOSK  one-hot, one-cycle pulse: job latched.
- done  out  N_KIOSK  one-hot, one-cycle pulse: ticket printed.
- fail  out  N_KIOSK  one-hot, one-cycle pulse: job rejected or timed out.
- prn_valid  out  1  job offered to the printer.
- prn_ready  in  1  printer accepts the job.
- prn_start, prn_dest  out  4 each  latched stations.
- prn_fare  out  7  latched fare.
- prn_done  in  1  printer finished, single-cycle strobe.
- busy  out  1  high in SEND or PRINT.
- owner  out  $clog2(N_KIOSK)  index of the kiosk currently granted.
- jobs_printed  out  8  count of successful jobs, wraps 255→0.

## Operation
- States: IDLE, SEND, PRINT. All outputs are registered.
- IDLE: if any req bit is high, select the first set bit scanning upward from rr_ptr, wrapping modulo N_KIOSK.
  - Latch that kiosk's fields into prn_start/prn_dest/prn_fare and set owner.
  - Pulse ack[owner]. Set rr_ptr = owner+1 mod N_KIOSK.
- Validation at grant: the job is invalid if start or dest is outside 1..10, start==dest, or fare==0.
  - Invalid job: ack and fail pulse in the same cycle, state stays IDLE, rr_ptr still advances.
  - Valid job: go to SEND and clear the watchdog.
- SEND: prn_valid=1 with stable fields. On prn_valid&&prn_ready go to PRINT and drop prn_valid.
- PRINT: wait for prn_done. On prn_done, pulse done[owner], increment jobs_printed, go to IDLE.
- Watchdog: 8-bit counter.
  - Cleared at grant; increments every cycle in SEND or PRINT.
  - When a transition would make it reach TIMEOUT with no completion: pulse fail[owner], drop prn_valid, go to IDLE.
  - prn_done in the same cycle as timeout: done wins.
- prn_done outside PRINT is ignored.
- req is ignored outside IDLE. A kiosk must drop req the cycle after ack; a still-high req is treated as a new job.
- Simultaneous requests: rotating priority guarantees each requester is granted within N_KIOSK grants.
- Reset values: state IDLE, rr_ptr 0, owner 0, all ack/done/fail 0, prn_valid 0, prn_* fields 0, busy 0, jobs_printed 0, watchdog 0.
- Reset mid-job: the job is abandoned silently, with no done or fail pulse and prn_valid low next cycle.

## Timing
- req sampled high at edge E: ack, prn_valid and busy are high after E+1.
- prn_ready high in the cycle after E+1: PRINT entered at E+2.
- prn_done sampled at edge D: done pulse and IDLE after D. The earliest next grant is at D+1, so there is 1 idle cycle between jobs.
- Timeout: fail pulse at edge ack_edge+TIMEOUT; busy falls the same edge.
- Invalid job: ack and fail both at E+1; the next grant is possible at E+2.
- ack, done and fail are exactly one cycle wide and never asserted for two kiosks at once.

## Test plan
- Single job: reset released, req[1] with start=2, dest=7, fare=50, prn_ready tied 1, prn_done 3 cycles after prn_valid.
  - Expect ack[1] at E+1, then prn_start=2, prn_dest=7, prn_fare=50.
  - Expect done[1] once, jobs_printed=1, busy low after done.
- Round robin: req=4'b1111 held, each job completed after 2 cycles.
  - Expect grant order 0,1,2,3,0.
  - Then rr_ptr=2 with req=4'b0011: expect grant 0 before 1.
- Invalid jobs: req[3] with start=dest=4 gives ack[3]+fail[3] same cycle, prn_valid never high, jobs_printed unchanged. Repeat with dest=11 and fare=0; same result.
- Timeout: TIMEOUT=16, prn_ready=0 forever. Expect fail[owner] exactly 16 cycles after ack and prn_valid low afterwards. Then prn_done pulsed in IDLE is ignored (no done).
- Done/timeout race: TIMEOUT=16, prn_done asserted in the cycle that hits the limit. Expect done only, no fail.
- Reset mid-PRINT: reset low for 1 cycle while in PRINT. Expect all outputs 0, no done/fail, rr_ptr=0, jobs_printed=0. Then a fresh req[2] is granted normally.
